// File: rtl/ahb_gpio_pkg.sv
// rtl/ahb_gpio_pkg.sv - shared constants and types for the AHB GPIO slave
package ahb_gpio_pkg;

   // Register word offsets, i.e. HADDR[4:2]
   localparam logic [2:0] ADDR_DATAOUT = 3'd0;
   localparam logic [2:0] ADDR_DATAIN  = 3'd1;
   localparam logic [2:0] ADDR_DIR     = 3'd2;
   localparam logic [2:0] ADDR_IRQMASK = 3'd3;
   localparam logic [2:0] ADDR_IRQSTAT = 3'd4;
   localparam logic [2:0] ADDR_PARSTAT = 3'd5;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic {
      PAR_EVEN = 1'b0,
      PAR_ODD  = 1'b1
   } par_mode_e;

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - input synchroniser, rising-edge detect and registered parity check
module gpio_in_sync #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W:0]   pins,
   input  logic [DATA_W-1:0] dir,
   input  logic              parity_sel,
   output logic [DATA_W-1:0] sync_data,
   output logic [DATA_W-1:0] rise,
   output logic              parity_err
);

   logic [DATA_W:0]   stage [SYNC_STAGES];
   logic [DATA_W:0]   sync_in;
   logic [DATA_W-1:0] prev;

   assign sync_in   = stage[SYNC_STAGES-1];
   assign sync_data = sync_in[DATA_W-1:0];
   // Pins configured as outputs are masked so driving them never raises an interrupt
   assign rise      = sync_in[DATA_W-1:0] & ~prev & ~dir;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
         prev       <= '0;
         parity_err <= 1'b0;
      end else begin
         stage[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
         prev       <= sync_in[DATA_W-1:0];
         parity_err <= (^sync_in) != parity_sel;
      end
   end

endmodule

// File: rtl/ahb_gpio_param.sv
// rtl/ahb_gpio_param.sv - AHB-Lite GPIO slave: bus decode, register file, parity generation
module ahb_gpio_param
   import ahb_gpio_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [31:0]       HRDATA,
   input  logic [DATA_W:0]   GPIOIN,
   output logic [DATA_W:0]   GPIOOUT,
   output logic [DATA_W-1:0] GPIOOE,
   input  logic              PARITYSEL,
   output logic              PARITYERR,
   output logic              IRQ
);

   logic              dp_valid;
   logic              dp_write;
   logic [2:0]        dp_addr;
   logic [DATA_W-1:0] dataout;
   logic [DATA_W-1:0] dir;
   logic [DATA_W-1:0] irqmask;
   logic [DATA_W-1:0] irqstat;
   logic              parstat;
   logic [DATA_W-1:0] sync_data;
   logic [DATA_W-1:0] rise;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] stat_clr;
   logic              par_clr;
   logic              wr_en;
   logic              addr_ok;
   logic [DATA_W-1:0] rdata;
   logic              unused_bits;

   gpio_in_sync #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_in_sync (
      .clk        (HCLK),
      .reset      (HRESET),
      .pins       (GPIOIN),
      .dir        (dir),
      .parity_sel (PARITYSEL),
      .sync_data  (sync_data),
      .rise       (rise),
      .parity_err (PARITYERR)
   );

   assign addr_ok  = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
   assign wr_en    = dp_valid & dp_write;
   assign wdata    = HWDATA[DATA_W-1:0];
   assign stat_clr = (wr_en && dp_addr == ADDR_IRQSTAT) ? wdata : '0;
   assign par_clr  = wr_en && dp_addr == ADDR_PARSTAT && HWDATA[0];

   assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HWDATA[31:DATA_W]};

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dataout  <= '0;
         dir      <= '0;
         irqmask  <= '0;
         irqstat  <= '0;
         parstat  <= 1'b0;
      end else begin
         dp_valid <= addr_ok;
         dp_write <= HWRITE;
         dp_addr  <= HADDR[4:2];
         if (wr_en && dp_addr == ADDR_DATAOUT) dataout <= wdata;
         if (wr_en && dp_addr == ADDR_DIR)     dir     <= wdata;
         if (wr_en && dp_addr == ADDR_IRQMASK) irqmask <= wdata;
         // Clear is applied before set so a simultaneous new event survives
         irqstat <= (irqstat & ~stat_clr) | rise;
         parstat <= (parstat & ~par_clr) | PARITYERR;
      end
   end

   always_comb begin
      rdata = '0;
      if (dp_valid && !dp_write) begin
         case (dp_addr)
            ADDR_DATAOUT: rdata = dataout;
            ADDR_DATAIN:  rdata = sync_data;
            ADDR_DIR:     rdata = dir;
            ADDR_IRQMASK: rdata = irqmask;
            ADDR_IRQSTAT: rdata = irqstat;
            ADDR_PARSTAT: rdata = {{(DATA_W-1){1'b0}}, parstat};
            default:      rdata = '0;
         endcase
      end
   end

   assign HRDATA    = {{(32-DATA_W){1'b0}}, rdata};
   assign HREADYOUT = 1'b1;
   assign GPIOOUT   = {(^dataout) ^ PARITYSEL, dataout};
   assign GPIOOE    = dir;
   assign IRQ       = |(irqstat & irqmask);

endmodule

// File: tb/tb_ahb_gpio_param.sv
// tb/tb_ahb_gpio_param.sv - directed table-driven bench for ahb_gpio_param
module tb_ahb_gpio_param;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic [16:0] GPIOIN;
   logic [16:0] GPIOOUT;
   logic [15:0] GPIOOE;
   logic        PARITYSEL;
   logic        PARITYERR;
   logic        IRQ;

   int errors = 0;
   int checks = 0;

   ahb_gpio_param #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
      .HRDATA(HRDATA), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT), .GPIOOE(GPIOOE),
      .PARITYSEL(PARITYSEL), .PARITYERR(PARITYERR), .IRQ(IRQ)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   // All bus tasks start and end 1 time unit after a rising edge
   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, output logic [31:0] hr);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
      cycles(1);
      idle();
      HWDATA = data;
      hr = HRDATA;
      cycles(1);
   endtask

   task automatic bus_rd(input logic [31:0] addr, output logic [31:0] hr);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
      cycles(1);
      idle();
      hr = HRDATA;
      cycles(1);
   endtask

   logic [31:0] got;

   initial begin
      HRESET = 1'b1; HREADY = 1'b1; HADDR = '0; HWDATA = '0;
      GPIOIN = '0; PARITYSEL = 1'b0;
      idle();
      cycles(2);
      check("rst_gpioout_even", {15'd0, GPIOOUT}, 32'h0);
      check("rst_gpiooe", {16'd0, GPIOOE}, 32'h0);
      check("rst_irq", {31'd0, IRQ}, 32'h0);
      check("rst_parityerr", {31'd0, PARITYERR}, 32'h0);
      check("rst_hreadyout", {31'd0, HREADYOUT}, 32'h1);
      check("rst_hrdata", HRDATA, 32'h0);
      PARITYSEL = 1'b1;
      #1;
      check("rst_gpioout_odd", {15'd0, GPIOOUT}, 32'h10000);
      PARITYSEL = 1'b0;
      HRESET = 1'b0;
      cycles(1);

      vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h0, "rd_dataout_rst"});
      vecs.push_back('{1'b0, 32'h04, 32'h0, 32'h0, "rd_datain_rst"});
      vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h0, "rd_dir_rst"});
      vecs.push_back('{1'b0, 32'h0C, 32'h0, 32'h0, "rd_irqmask_rst"});
      vecs.push_back('{1'b0, 32'h10, 32'h0, 32'h0, "rd_irqstat_rst"});
      vecs.push_back('{1'b0, 32'h14, 32'h0, 32'h0, "rd_parstat_rst"});
      vecs.push_back('{1'b1, 32'h00, 32'h000000A5, 32'h0, "wr_dataout"});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h000000A5, "rd_dataout"});
      vecs.push_back('{1'b1, 32'h08, 32'hFFFF1234, 32'h0, "wr_dir"});
      vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h00001234, "rd_dir_upper_ignored"});
      vecs.push_back('{1'b1, 32'h0C, 32'h00000001, 32'h0, "wr_irqmask"});
      vecs.push_back('{1'b0, 32'h0C, 32'h0, 32'h00000001, "rd_irqmask"});
      vecs.push_back('{1'b1, 32'h18, 32'h0000FFFF, 32'h0, "wr_unmapped"});
      vecs.push_back('{1'b0, 32'h18, 32'h0, 32'h0, "rd_0x18"});
      vecs.push_back('{1'b0, 32'h1C, 32'h0, 32'h0, "rd_0x1c"});
      vecs.push_back('{1'b1, 32'h04, 32'h0000FFFF, 32'h0, "wr_datain"});
      vecs.push_back('{1'b0, 32'h04, 32'h0, 32'h0, "rd_datain_ro"});
      vecs.push_back('{1'b1, 32'h08, 32'h00000000, 32'h0, "wr_dir_zero"});
      vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h0, "rd_dir_zero"});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h000000A5, "rd_dataout_kept"});

      foreach (vecs[i]) begin
         if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data, got);
         else            bus_rd(vecs[i].addr, got);
         check(vecs[i].name, got, vecs[i].exp);
      end

      check("gpioout_a5_even", {15'd0, GPIOOUT}, 32'h000A5);
      PARITYSEL = 1'b1;
      #1;
      check("gpioout_a5_odd", {15'd0, GPIOOUT}, 32'h100A5);
      PARITYSEL = 1'b0;
      bus_wr(32'h00, 32'h7, got);
      check("gpioout_7_even", {15'd0, GPIOOUT}, 32'h10007);

      // Back-to-back write then read of DIR
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08;
      cycles(1);
      HWDATA = 32'h00FF; HWRITE = 1'b0; HADDR = 32'h08;
      cycles(1);
      idle();
      check("b2b_rd_dir", HRDATA, 32'h00FF);
      check("gpiooe_ff", {16'd0, GPIOOE}, 32'h00FF);
      cycles(1);
      bus_wr(32'h08, 32'h0, got);

      // Input path and interrupt latency
      GPIOIN = 17'h0_0003;
      cycles(1);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h04;
      cycles(1);
      idle();
      check("datain_2cyc", HRDATA, 32'h3);
      check("irq_before_3cyc", {31'd0, IRQ}, 32'h0);
      cycles(1);
      check("irq_3cyc", {31'd0, IRQ}, 32'h1);
      check("parityerr_even_ok", {31'd0, PARITYERR}, 32'h0);
      bus_rd(32'h10, got);
      check("irqstat_3", got, 32'h3);
      bus_wr(32'h10, 32'h2, got);
      check("irq_after_clr_bit1", {31'd0, IRQ}, 32'h1);
      bus_rd(32'h10, got);
      check("irqstat_after_clr_bit1", got, 32'h1);
      bus_wr(32'h10, 32'h1, got);
      check("irq_after_clr_bit0", {31'd0, IRQ}, 32'h0);

      // Direction gating
      GPIOIN = '0;
      cycles(4);
      bus_wr(32'h08, 32'h1, got);
      GPIOIN = 17'h0_0003;
      cycles(4);
      bus_rd(32'h10, got);
      check("dir_gating", got, 32'h2);
      bus_wr(32'h10, 32'hFFFF, got);
      bus_wr(32'h08, 32'h0, got);
      GPIOIN = '0;
      cycles(4);

      // Parity error detection and sticky status
      GPIOIN = 17'h0_0001;
      cycles(2);
      check("parityerr_2cyc", {31'd0, PARITYERR}, 32'h0);
      cycles(1);
      check("parityerr_3cyc", {31'd0, PARITYERR}, 32'h1);
      GPIOIN = 17'h1_0001;
      cycles(5);
      check("parityerr_fixed", {31'd0, PARITYERR}, 32'h0);
      bus_rd(32'h14, got);
      check("parstat_sticky", got, 32'h1);
      bus_wr(32'h14, 32'h1, got);
      bus_rd(32'h14, got);
      check("parstat_cleared", got, 32'h0);
      PARITYSEL = 1'b1;
      cycles(1);
      check("parityerr_sel_odd", {31'd0, PARITYERR}, 32'h1);
      PARITYSEL = 1'b0;
      cycles(1);
      check("parityerr_sel_even", {31'd0, PARITYERR}, 32'h0);

      // W1C on IRQSTAT coinciding with a new edge on the same bit
      bus_wr(32'h10, 32'hFFFF, got);
      bus_rd(32'h10, got);
      check("irqstat_pre_race", got, 32'h0);
      GPIOIN = 17'h0_0005;
      cycles(1);
      bus_wr(32'h10, 32'h4, got);
      bus_rd(32'h10, got);
      check("w1c_vs_set", got, 32'h4);

      // Writes that must not be accepted
      HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h00;
      cycles(1);
      HWDATA = 32'h1111;
      HTRANS = 2'b10; HREADY = 1'b0;
      cycles(1);
      HWDATA = 32'h2222; HREADY = 1'b1;
      idle();
      cycles(1);
      bus_rd(32'h00, got);
      check("idle_notready_ignored", got, 32'h7);

      // Reset during a write data phase
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
      cycles(1);
      idle();
      HWDATA = 32'h5A5A; HRESET = 1'b1;
      check("hreadyout_in_reset", {31'd0, HREADYOUT}, 32'h1);
      cycles(1);
      HRESET = 1'b0;
      check("rst_abort_gpioout", {15'd0, GPIOOUT}, 32'h0);
      bus_rd(32'h00, got);
      check("rst_abort_dataout", got, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_gpio_param.md
# ahb_gpio_param

Parametrised AHB-Lite GPIO slave, the next generation of the team's AHBGPIO block. It adds configurable port width, per-bit direction control, an input synchroniser, rising-edge interrupts with mask and write-1-to-clear status, and even/odd parity generation and checking with a sticky error flag. It sits on the AHB-Lite bus as a zero-wait-state slave and drives the chip's GPIO pads.

## Interface
Parameters:
- DATA_W, 16: GPIO data width, legal range 2..31; the parity bit is extra.
- SYNC_STAGES, 2: flop stages on GPIOIN, legal range 2..3.

Ports:
- HCLK  in  1  single clock for all logic.
- HRESET  in  1  synchronous, active-high reset, sampled on the HCLK rising edge.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; only [4:2] is decoded.
- HTRANS  in  2  transfer type; a transfer is valid when HTRANS[1]=1 (NONSEQ or SEQ).
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready; address phase is accepted only when HREADY=1.
- HREADYOUT  out  1  tied to 1 (zero wait states).
- HRDATA  out  32  read data in the data phase.
- GPIOIN  in  DATA_W+1  pad inputs; bit DATA_W is the parity bit.
- GPIOOUT  out  DATA_W+1  pad outputs; bit DATA_W is the generated parity.
- GPIOOE  out  DATA_W  per-bit output enable, equal to DIR.
- PARITYSEL  in  1  0 = even parity, 1 = odd parity.
- PARITYERR  out  1  registered parity mismatch for the current sampled input.
- IRQ  out  1  |(IRQSTAT & IRQMASK).

## Operation
- Address phase is captured when HSEL & HREADY & HTRANS[1]. The captured address and HWRITE drive the following data phase.
- Register map (offset, access):
  - 0x00 DATAOUT, RW.
  - 0x04 DATAIN, RO: synchronised GPIOIN[DATA_W-1:0].
  - 0x08 DIR, RW: 1 = output.
  - 0x0C IRQMASK, RW.
  - 0x10 IRQSTAT, W1C.
  - 0x14 PARSTAT, W1C: bit0 is the sticky parity error.
- Bits above DATA_W read as 0 and ignore writes. Unmapped offsets (0x18, 0x1C) read as 0 and ignore writes. Writes to DATAIN are ignored.
- GPIOOUT[DATA_W-1:0] = DATAOUT.
- GPIOOUT[DATA_W] = ^DATAOUT ^ PARITYSEL (combinational), so the total count of ones is even when PARITYSEL=0 and odd when PARITYSEL=1.
- Input check: PARITYERR is registered as (^sync_in[DATA_W:0]) != PARITYSEL. PARSTAT[0] is set whenever PARITYERR=1.
- Edge detect: IRQSTAT[i] is set when sync_in[i] & ~prev[i] & ~DIR[i]. Output bits never raise interrupts.
- Clearing: W1C clears the written-1 bits. If a set and a clear hit the same bit in the same cycle, the set wins. The same rule applies to PARSTAT.
- HRDATA is combinational from the data-phase address and the current registers. It is 0 when the data phase is a write or idle.
- Reset values:
  - All registers, sync flops and prev are 0; PARITYERR=0; IRQ=0; GPIOOE=0.
  - GPIOOUT[DATA_W-1:0]=0 and GPIOOUT[DATA_W]=PARITYSEL.
  - HREADYOUT=1 and HRDATA=0.
- Reset asserted mid-transfer aborts the pending data-phase write and clears all state on that edge.

## Timing
- A write whose data phase is in cycle N updates the register at the end of N. GPIOOUT and GPIOOE change in N+1.
- Back-to-back write then read of the same register returns the new value (zero wait states).
- GPIOIN to DATAIN visibility: SYNC_STAGES cycles.
- GPIOIN to IRQSTAT/IRQ: SYNC_STAGES+1 cycles.
- GPIOIN to PARITYERR: SYNC_STAGES+1 cycles.
- A PARITYSEL change affects GPIOOUT[DATA_W] in the same cycle and PARITYERR on the next edge.
- HREADYOUT is 1 in all cycles, including during reset.

## Structure
- Package ahb_gpio_pkg holds:
  - register offset constants ADDR_DATAOUT .. ADDR_PARSTAT;
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - a parity-mode enum (PAR_EVEN, PAR_ODD).
- Sub-module gpio_in_sync contains the SYNC_STAGES synchroniser, the prev register, the rising-edge vector and the registered PARITYERR. The top contains the bus decode and the register file.

## Test plan
- Reset: assert HRESET for 2 cycles. Expect all registers to read 0, GPIOOUT=0x00000 with PARITYSEL=0, and GPIOOUT[16]=1 when PARITYSEL=1.
- Write and read back: with DATA_W=16, write DATAOUT=0x00A5, then read it in the next transfer. Expect HRDATA=0x00A5 and GPIOOUT=0x0A5 | (0<<16) (even parity, four ones). With PARITYSEL=1, expect GPIOOUT[16]=1.
- Input path: DIR=0, drive GPIOIN=0x0_0003. After 2 cycles DATAIN=0x0003. With IRQMASK=0x0001, IRQ rises 3 cycles after the input change. Writing IRQSTAT=0x0001 clears it; writing IRQSTAT=0x0002 does not.
- Direction gating: DIR=0x0001 with a rising edge on GPIOIN[0] leaves IRQSTAT[0]=0. The same edge on bit 1 sets IRQSTAT[1].
- Parity error: PARITYSEL=0, drive GPIOIN=0x0_0001 (odd count). Expect PARITYERR=1 after 3 cycles and PARSTAT=1 sticky after the input is fixed to 0x1_0001. A W1C to PARSTAT clears it.
- Edge cases:
  - A W1C to IRQSTAT in the same cycle as a new edge on the same bit leaves the bit set.
  - A read of 0x18 returns 0.
  - HTRANS=IDLE or HREADY=0 writes change nothing.
  - Reset during a write data phase discards the write.
